ctrl_fsm: RTL and testbench

Multi-cycle sequencing controller for the RV32I core. Consumes the 5-bit major opcode and `invalid` flag from the instruction decoder, the datapath branch-compare result and a single-beat memory handshake. Drives every write enable and mux select in the datapath: instruction register, PC, register file, ALU operands, writeback source and memory request. One instruction is in flight at a time; there is no pipelining.

---
 rtl/ctrl_fsm_pkg.sv | 47 ++++
 rtl/ctrl_fsm_if.sv | 35 +++
 rtl/ctrl_fsm_perf.sv | 34 +++
 rtl/ctrl_fsm.sv | 172 +++++++++++++++++
 tb/tb_ctrl_fsm.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_fsm_pkg.sv
// Shared control definitions for the RV32I multi-cycle core: state encoding,
// major opcodes and datapath mux encodings used by decoder, datapath and ctrl_fsm.
package ctrl_pkg;

   typedef enum logic [2:0] {
      ST_RESET  = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_TRAP   = 3'd6
   } state_t;

   localparam logic [4:0] OPC_LUI    = 5'b01101;
   localparam logic [4:0] OPC_AUIPC  = 5'b00101;
   localparam logic [4:0] OPC_JAL    = 5'b11011;
   localparam logic [4:0] OPC_JALR   = 5'b11001;
   localparam logic [4:0] OPC_BRANCH = 5'b11000;
   localparam logic [4:0] OPC_LOAD   = 5'b00000;
   localparam logic [4:0] OPC_STORE  = 5'b01000;
   localparam logic [4:0] OPC_OPIMM  = 5'b00100;
   localparam logic [4:0] OPC_OP     = 5'b01100;
   localparam logic [4:0] OPC_FENCE  = 5'b00011;
   localparam logic [4:0] OPC_SYSTEM = 5'b11100;

   localparam logic [1:0] PC_SEL_PLUS4 = 2'd0;
   localparam logic [1:0] PC_SEL_IMM   = 2'd1;
   localparam logic [1:0] PC_SEL_JALR  = 2'd2;

   localparam logic [1:0] WB_SEL_ALU = 2'd0;
   localparam logic [1:0] WB_SEL_MEM = 2'd1;
   localparam logic [1:0] WB_SEL_PC4 = 2'd2;
   localparam logic [1:0] WB_SEL_IMM = 2'd3;

   // SYSTEM is deliberately absent: ECALL/EBREAK/CSR all trap in this core.
   function automatic logic opc_supported(input logic [4:0] opc);
      logic v_ok;
      case (opc)
         OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
         OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP, OPC_FENCE: v_ok = 1'b1;
         default:                                           v_ok = 1'b0;
      endcase
      return v_ok;
   endfunction

endpackage

// File: rtl/ctrl_fsm_if.sv
// Decoder/datapath/memory signals seen by the sequencing controller.
// master = controller side, slave = datapath/bench side.
interface ctrl_fsm_if #(parameter int CNT_W = 32);

   logic [4:0]       opcode;
   logic             invalid;
   logic             br_taken;
   logic             mem_ack;
   logic             mem_req;
   logic             mem_we;
   logic             ir_we;
   logic             pc_we;
   logic [1:0]       pc_sel;
   logic             rf_we;
   logic [1:0]       wb_sel;
   logic             alu_a_sel;
   logic             alu_b_sel;
   logic             trap;
   logic [2:0]       state;
   logic [CNT_W-1:0] cycle_cnt;
   logic [CNT_W-1:0] instret_cnt;

   modport master (
      input  opcode, invalid, br_taken, mem_ack,
      output mem_req, mem_we, ir_we, pc_we, pc_sel, rf_we, wb_sel,
             alu_a_sel, alu_b_sel, trap, state, cycle_cnt, instret_cnt
   );

   modport slave (
      output opcode, invalid, br_taken, mem_ack,
      input  mem_req, mem_we, ir_we, pc_we, pc_sel, rf_we, wb_sel,
             alu_a_sel, alu_b_sel, trap, state, cycle_cnt, instret_cnt
   );

endinterface

// File: rtl/ctrl_fsm_perf.sv
// Free-running cycle and retired-instruction counters; wrap modulo 2^CNT_W.
module ctrl_perf #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_count_en,
   input  logic             i_retire,
   output logic [CNT_W-1:0] o_cycle_cnt,
   output logic [CNT_W-1:0] o_instret_cnt
);

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] r_cycle_cnt;
   logic [CNT_W-1:0] r_instret_cnt;

   // Counter registers, cleared asynchronously with the controller.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cycle_cnt   <= {CNT_W{1'b0}};
         r_instret_cnt <= {CNT_W{1'b0}};
      end else begin
         if (i_count_en) r_cycle_cnt <= r_cycle_cnt + ONE;
         else            r_cycle_cnt <= r_cycle_cnt;
         if (i_retire)   r_instret_cnt <= r_instret_cnt + ONE;
         else            r_instret_cnt <= r_instret_cnt;
      end
   end

   assign o_cycle_cnt   = r_cycle_cnt;
   assign o_instret_cnt = r_instret_cnt;

endmodule

// File: rtl/ctrl_fsm.sv
// Multi-cycle RV32I sequencing controller (one instruction in flight).
// Define CTRL_PERF_EN to build the cycle/instret counters; otherwise they read 0.
module ctrl_fsm
   import ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   ctrl_fsm_if.master bus
);

   state_t           r_state;
   state_t           w_next;
   logic             r_rst_hold;
   logic             r_trap;
   logic             w_mem_req;
   logic             w_mem_we;
   logic             w_ir_we;
   logic             w_pc_we;
   logic [1:0]       w_pc_sel;
   logic             w_rf_we;
   logic [1:0]       w_wb_sel;
   logic             w_alu_a_sel;
   logic             w_alu_b_sel;
   logic [CNT_W-1:0] w_cycle_cnt;
   logic [CNT_W-1:0] w_instret_cnt;

   // State register; r_rst_hold keeps RESET for one full cycle after release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_RESET;
         r_rst_hold <= 1'b0;
         r_trap     <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_rst_hold <= 1'b1;
         r_trap     <= (w_next == ST_TRAP);
      end
   end

   // Next state and datapath enables.
   always_comb begin
      w_next    = r_state;
      w_mem_req = 1'b0;
      w_mem_we  = 1'b0;
      w_ir_we   = 1'b0;
      w_pc_we   = 1'b0;
      w_pc_sel  = PC_SEL_PLUS4;
      w_rf_we   = 1'b0;
      w_wb_sel  = WB_SEL_ALU;
      case (r_state)
         ST_RESET: begin
            if (r_rst_hold) w_next = ST_FETCH;
            else            w_next = ST_RESET;
         end
         ST_FETCH: begin
            w_mem_req = 1'b1;
            if (bus.mem_ack) begin
               w_ir_we = 1'b1;
               w_next  = ST_DECODE;
            end else begin
               w_next  = ST_FETCH;
            end
         end
         ST_DECODE: begin
            if (bus.invalid || !opc_supported(bus.opcode)) w_next = ST_TRAP;
            else                                           w_next = ST_EXEC;
         end
         ST_EXEC: begin
            case (bus.opcode)
               OPC_LOAD, OPC_STORE: w_next = ST_MEM;
               OPC_BRANCH: begin
                  w_pc_we  = 1'b1;
                  w_pc_sel = bus.br_taken ? PC_SEL_IMM : PC_SEL_PLUS4;
                  w_next   = ST_FETCH;
               end
               OPC_FENCE: begin
                  w_pc_we = 1'b1;
                  w_next  = ST_FETCH;
               end
               default: w_next = ST_WB;
            endcase
         end
         ST_MEM: begin
            w_mem_req = 1'b1;
            w_mem_we  = (bus.opcode == OPC_STORE);
            if (bus.mem_ack) begin
               if (bus.opcode == OPC_STORE) begin
                  w_pc_we = 1'b1;
                  w_next  = ST_FETCH;
               end else begin
                  w_next  = ST_WB;
               end
            end else begin
               w_next = ST_MEM;
            end
         end
         ST_WB: begin
            w_rf_we = 1'b1;
            w_pc_we = 1'b1;
            w_next  = ST_FETCH;
            case (bus.opcode)
               OPC_JAL: begin
                  w_wb_sel = WB_SEL_PC4;
                  w_pc_sel = PC_SEL_IMM;
               end
               OPC_JALR: begin
                  w_wb_sel = WB_SEL_PC4;
                  w_pc_sel = PC_SEL_JALR;
               end
               OPC_LOAD: w_wb_sel = WB_SEL_MEM;
               OPC_LUI:  w_wb_sel = WB_SEL_IMM;
               default:  w_wb_sel = WB_SEL_ALU;
            endcase
         end
         ST_TRAP: w_next = ST_TRAP;
         default: w_next = ST_RESET;
      endcase
   end

   // ALU selects stay valid through MEM and WB so address and result are stable.
   always_comb begin
      w_alu_a_sel = 1'b0;
      w_alu_b_sel = 1'b0;
      if (r_state == ST_EXEC || r_state == ST_MEM || r_state == ST_WB) begin
         case (bus.opcode)
            OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_JALR: w_alu_b_sel = 1'b1;
            OPC_AUIPC: begin
               w_alu_a_sel = 1'b1;
               w_alu_b_sel = 1'b1;
            end
            default: begin
               w_alu_a_sel = 1'b0;
               w_alu_b_sel = 1'b0;
            end
         endcase
      end else begin
         w_alu_a_sel = 1'b0;
         w_alu_b_sel = 1'b0;
      end
   end

`ifdef CTRL_PERF_EN
   ctrl_perf #(.CNT_W(CNT_W)) u_perf (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_count_en    (r_state != ST_RESET),
      .i_retire      (w_pc_we),
      .o_cycle_cnt   (w_cycle_cnt),
      .o_instret_cnt (w_instret_cnt)
   );
`else
   assign w_cycle_cnt   = {CNT_W{1'b0}};
   assign w_instret_cnt = {CNT_W{1'b0}};
`endif

   assign bus.mem_req     = w_mem_req;
   assign bus.mem_we      = w_mem_we;
   assign bus.ir_we       = w_ir_we;
   assign bus.pc_we       = w_pc_we;
   assign bus.pc_sel      = w_pc_sel;
   assign bus.rf_we       = w_rf_we;
   assign bus.wb_sel      = w_wb_sel;
   assign bus.alu_a_sel   = w_alu_a_sel;
   assign bus.alu_b_sel   = w_alu_b_sel;
   assign bus.trap        = r_trap;
   assign bus.state       = r_state;
   assign bus.cycle_cnt   = w_cycle_cnt;
   assign bus.instret_cnt = w_instret_cnt;

endmodule

// File: tb/tb_ctrl_fsm.sv
// Self-checking bench for ctrl_fsm: directed and random instructions against a
// per-instruction reference model (state trace, counts of enables, selects, counters).
module tb_ctrl_fsm;
   import ctrl_pkg::*;

`ifdef CTRL_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic clk;
   logic rst_n = 1'b1;
   ctrl_fsm_if #(.CNT_W(32)) bus ();

   ctrl_fsm #(.CNT_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int          total = 0;
   int          bad   = 0;
   logic [31:0] exp_cyc = 32'd0;
   logic [31:0] exp_ret = 32'd0;
   state_t      exp_q[$];
   logic [4:0]  legal_ops [10] = '{5'b01101, 5'b00101, 5'b11011, 5'b11001, 5'b11000,
                                   5'b00000, 5'b01000, 5'b00100, 5'b01100, 5'b00011};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic bit is_legal(input logic [4:0] o, input logic inv);
      return !inv && (o inside {5'b01101, 5'b00101, 5'b11011, 5'b11001, 5'b11000,
                                5'b00000, 5'b01000, 5'b00100, 5'b01100, 5'b00011});
   endfunction

   // Expected per-cycle state sequence of one instruction, from FETCH to its last cycle.
   task automatic build_exp(input logic [4:0] o, input logic inv, input int fw, input int mw);
      exp_q.delete();
      repeat (1 + fw) exp_q.push_back(ST_FETCH);
      exp_q.push_back(ST_DECODE);
      if (is_legal(o, inv)) begin
         exp_q.push_back(ST_EXEC);
         if (o == 5'b00000 || o == 5'b01000) repeat (1 + mw) exp_q.push_back(ST_MEM);
         if (!(o inside {5'b11000, 5'b00011, 5'b01000})) exp_q.push_back(ST_WB);
      end
   endtask

   // Called at a negedge with the DUT in its first FETCH cycle.
   task automatic run_insn(input string nm, input logic [4:0] o, input logic inv,
                           input int fw, input int mw, input logic br);
      state_t     trace[$];
      int         reqc = 0, phase = 0, cyc = 0;
      int         nreq = 0, nst = 0, nir = 0, nrf = 0, nret = 0, mism = 0;
      logic [1:0] pcs = 2'd0, wbs = 2'd0;
      logic       a_rf = 1'b0, b_rf = 1'b0, ack, done = 1'b0;
      bit         lg, ls;
      int         exp_req, exp_st;
      logic [1:0] exp_wb, exp_pc;

      bus.opcode = o; bus.invalid = inv; bus.br_taken = br;
      check({nm, "_cycle_cnt"}, bus.cycle_cnt, PERF ? exp_cyc : 32'd0);
      check({nm, "_instret_cnt"}, bus.instret_cnt, PERF ? exp_ret : 32'd0);
      while (!done && cyc < 64) begin
         if (bus.state === ST_TRAP) begin
            done = 1'b1;
         end else begin
            if (bus.mem_req) begin
               ack = (reqc == ((phase == 0) ? fw : mw));
               reqc++;
            end else begin
               ack = 1'($urandom_range(0, 1));
            end
            bus.mem_ack = ack;
            #1;
            trace.push_back(state_t'(bus.state));
            if (bus.mem_req) nreq++;
            if (bus.mem_req && bus.mem_we) nst++;
            if (bus.ir_we) nir++;
            if (bus.rf_we) begin
               nrf++; wbs = bus.wb_sel; a_rf = bus.alu_a_sel; b_rf = bus.alu_b_sel;
            end
            if (bus.pc_we) begin
               nret++; pcs = bus.pc_sel; done = 1'b1;
            end
            if (bus.mem_req && ack) begin
               phase = 1; reqc = 0;
            end
            cyc++;
            @(negedge clk);
         end
      end
      check({nm, "_timeout"}, done, 1'b1);

      build_exp(o, inv, fw, mw);
      lg = is_legal(o, inv);
      ls = lg && (o == 5'b00000 || o == 5'b01000);
      exp_req = (1 + fw) + (ls ? 1 + mw : 0);
      exp_st  = (lg && o == 5'b01000) ? 1 + mw : 0;
      exp_wb  = (o == 5'b11011 || o == 5'b11001) ? 2'd2 : (o == 5'b00000) ? 2'd1 :
                (o == 5'b01101) ? 2'd3 : 2'd0;
      exp_pc  = (o == 5'b11011) ? 2'd1 : (o == 5'b11001) ? 2'd2 :
                (o == 5'b11000) ? {1'b0, br} : 2'd0;
      check({nm, "_ncycles"}, trace.size(), exp_q.size());
      for (int i = 0; i < trace.size() && i < exp_q.size(); i++)
         if (trace[i] != exp_q[i]) mism++;
      check({nm, "_trace"}, mism, 0);
      check({nm, "_mem_req_cycles"}, nreq, exp_req);
      check({nm, "_store_cycles"}, nst, exp_st);
      check({nm, "_ir_we"}, nir, 1);
      check({nm, "_rf_we"}, nrf, (lg && !(o inside {5'b11000, 5'b00011, 5'b01000})) ? 1 : 0);
      check({nm, "_retire"}, nret, lg ? 1 : 0);
      check({nm, "_trap"}, bus.trap, !lg);
      if (nrf > 0) check({nm, "_wb_sel"}, wbs, exp_wb);
      if (nret > 0) check({nm, "_pc_sel"}, pcs, exp_pc);
      if (lg && o inside {5'b01100, 5'b00100, 5'b00000, 5'b11001, 5'b00101}) begin
         check({nm, "_alu_a"}, a_rf, o == 5'b00101);
         check({nm, "_alu_b"}, b_rf, o != 5'b01100);
      end
      exp_cyc += 32'(trace.size());
      if (lg) exp_ret += 32'd1;
   endtask

   // Trap must be quiet: no requests or enables whatever mem_ack does.
   task automatic trap_hold(input string nm);
      repeat (6) begin
         bus.mem_ack = 1'($urandom_range(0, 1));
         #1;
         check({nm, "_quiet"}, {bus.mem_req, bus.ir_we, bus.pc_we, bus.rf_we}, 4'b0000);
         check({nm, "_sticky"}, bus.trap, 1'b1);
         @(negedge clk);
      end
   endtask

   // Asserts reset (with a pending ack), checks it, then releases and waits for FETCH.
   task automatic do_reset(input string nm);
      bus.mem_ack = 1'b1;
      rst_n = 1'b0;
      #1;
      check({nm, "_state"}, bus.state, ST_RESET);
      check({nm, "_enables"}, {bus.mem_req, bus.ir_we, bus.pc_we, bus.rf_we}, 4'b0000);
      check({nm, "_trap"}, bus.trap, 1'b0);
      check({nm, "_cycle_cnt"}, bus.cycle_cnt, 32'd0);
      check({nm, "_instret_cnt"}, bus.instret_cnt, 32'd0);
      repeat (2) @(negedge clk);
      bus.mem_ack = 1'b0;
      rst_n = 1'b1;
      #1;
      check({nm, "_rel0"}, bus.state, ST_RESET);
      @(negedge clk);
      #1;
      check({nm, "_rel1"}, {bus.state, bus.mem_req}, {ST_RESET, 1'b0});
      @(negedge clk);
      check({nm, "_fetch"}, {bus.state, bus.mem_req, bus.mem_we}, {ST_FETCH, 1'b1, 1'b0});
      exp_cyc = 32'd0;
      exp_ret = 32'd0;
   endtask

   initial begin
      int idx;
      bus.opcode = 5'd0; bus.invalid = 1'b0; bus.br_taken = 1'b0; bus.mem_ack = 1'b0;
      @(negedge clk);
      do_reset("rst0");

      run_insn("addi", 5'b00100, 1'b0, 0, 0, 1'b0);
      run_insn("load_w3", 5'b00000, 1'b0, 0, 3, 1'b0);
      run_insn("br_t", 5'b11000, 1'b0, 0, 0, 1'b1);
      run_insn("br_nt", 5'b11000, 1'b0, 0, 0, 1'b0);
      run_insn("jalr", 5'b11001, 1'b0, 0, 0, 1'b0);
      run_insn("store", 5'b01000, 1'b0, 1, 2, 1'b1);
      run_insn("lui", 5'b01101, 1'b0, 2, 0, 1'b0);
      run_insn("auipc", 5'b00101, 1'b0, 0, 0, 1'b0);
      run_insn("jal", 5'b11011, 1'b0, 0, 0, 1'b1);
      run_insn("op", 5'b01100, 1'b0, 0, 0, 1'b0);
      run_insn("fence", 5'b00011, 1'b0, 0, 0, 1'b1);

      for (int n = 0; n < 40; n++) begin
         idx = int'($urandom_range(0, 9));
         run_insn("rnd", legal_ops[idx], 1'b0, int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end

      run_insn("ill_inv", 5'b00100, 1'b1, 1, 0, 1'b0);
      trap_hold("ill_inv");
      do_reset("rst_inv");
      run_insn("ill_sys", 5'b11100, 1'b0, 0, 0, 1'b0);
      trap_hold("ill_sys");
      do_reset("rst_sys");
      run_insn("ill_1f", 5'b11111, 1'b0, 2, 0, 1'b0);
      trap_hold("ill_1f");
      do_reset("rst_1f");

      run_insn("pre_addi", 5'b00100, 1'b0, 0, 0, 1'b0);
      bus.opcode = 5'b00000;
      bus.mem_ack = 1'b0;
      repeat (2) @(negedge clk);
      #2;
      do_reset("rst_mid_fetch");
      run_insn("post_lw", 5'b00000, 1'b0, 0, 1, 1'b0);
      run_insn("post_addi", 5'b00100, 1'b0, 0, 0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
